// File: rtl/spio_uart_frac_baud_gen.sv
// Fractional-N UART subsample/baud tick generator with SYNC_IN phase restart.
// Define SPIO_UART_BAUD_GEN_MID_PULSE_EN to generate the mid-bit MID_PULSE_OUT tick.
module spio_uart_frac_baud_gen #(
    parameter int NUM_BITS        = 16,
    parameter int FRAC_BITS       = 4,
    parameter int OVERSAMPLE_LOG2 = 3
) (
    input  logic                       CLK_IN,
    input  logic                       RESET_IN,
    input  logic                       ENABLE_IN,
    input  logic                       SYNC_IN,
    input  logic [NUM_BITS-1:0]        DIV_INT_IN,
    input  logic [FRAC_BITS-1:0]       DIV_FRAC_IN,
    output logic                       SUBSAMPLE_PULSE_OUT,
    output logic [OVERSAMPLE_LOG2-1:0] SUBSAMPLE_IDX_OUT,
    output logic                       BAUD_PULSE_OUT,
    output logic                       MID_PULSE_OUT
);

    localparam logic [OVERSAMPLE_LOG2-1:0] IDX_LAST = '1;

    logic [NUM_BITS-1:0]        cnt_i;
    logic [FRAC_BITS-1:0]       acc_i;
    logic [OVERSAMPLE_LOG2-1:0] idx_i;
    logic                       started_i;

    logic [NUM_BITS-1:0]        div_eff;
    logic [FRAC_BITS:0]         acc_sum;
    logic                       load;
    logic                       run;
    logic                       tick;

    // A zero integer divisor behaves as one so the counter never underflows.
    assign div_eff = (DIV_INT_IN == '0) ? NUM_BITS'(1) : DIV_INT_IN;
    assign acc_sum = {1'b0, acc_i} + {1'b0, DIV_FRAC_IN};
    assign load    = SYNC_IN | (ENABLE_IN & ~started_i);
    assign run     = ENABLE_IN & started_i & ~SYNC_IN;
    assign tick    = run & (cnt_i == '0);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            cnt_i               <= '0;
            acc_i               <= '0;
            idx_i               <= '0;
            started_i           <= 1'b0;
            SUBSAMPLE_PULSE_OUT <= 1'b0;
            SUBSAMPLE_IDX_OUT   <= '0;
            BAUD_PULSE_OUT      <= 1'b0;
        end else begin
            SUBSAMPLE_PULSE_OUT <= 1'b0;
            BAUD_PULSE_OUT      <= 1'b0;
            if (load) begin
                cnt_i     <= div_eff - NUM_BITS'(1);
                acc_i     <= '0;
                idx_i     <= '0;
                started_i <= 1'b1;
            end else if (tick) begin
                // The accumulator carry stretches this period by one clock.
                cnt_i               <= div_eff - NUM_BITS'(1) + NUM_BITS'(acc_sum[FRAC_BITS]);
                acc_i               <= acc_sum[FRAC_BITS-1:0];
                idx_i               <= idx_i + OVERSAMPLE_LOG2'(1);
                SUBSAMPLE_PULSE_OUT <= 1'b1;
                SUBSAMPLE_IDX_OUT   <= idx_i;
                BAUD_PULSE_OUT      <= (idx_i == IDX_LAST);
            end else if (run) begin
                cnt_i <= cnt_i - NUM_BITS'(1);
            end
        end
    end

`ifdef SPIO_UART_BAUD_GEN_MID_PULSE_EN
    localparam logic [OVERSAMPLE_LOG2-1:0] IDX_MID = OVERSAMPLE_LOG2'((2 ** (OVERSAMPLE_LOG2 - 1)) - 1);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            MID_PULSE_OUT <= 1'b0;
        end else begin
            MID_PULSE_OUT <= tick & ~load & (idx_i == IDX_MID);
        end
    end
`else
    assign MID_PULSE_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_spio_uart_frac_baud_gen.sv
// Scoreboard bench for spio_uart_frac_baud_gen: a reference model queues expected
// tick events, a negedge monitor queues observed ones, and each test compares them.
module tb_spio_uart_frac_baud_gen;

    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  idx;
        logic        baud;
        logic        mid;
        logic        pulse;
    } ev_t;

`ifdef SPIO_UART_BAUD_GEN_MID_PULSE_EN
    localparam bit MID_ON = 1'b1;
`else
    localparam bit MID_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sync = 1'b0;
    logic [15:0] div_int = 16'd4;
    logic [3:0]  div_frac = 4'd0;
    logic        sub_pulse;
    logic [2:0]  sub_idx;
    logic        baud_pulse;
    logic        mid_pulse;

    int  cyc = 0;
    int  n_compared = 0;
    int  n_mismatched = 0;
    ev_t obs[$];
    ev_t exp_q[$];

    spio_uart_frac_baud_gen dut (
        .CLK_IN              (clk),
        .RESET_IN            (reset),
        .ENABLE_IN           (enable),
        .SYNC_IN             (sync),
        .DIV_INT_IN          (div_int),
        .DIV_FRAC_IN         (div_frac),
        .SUBSAMPLE_PULSE_OUT (sub_pulse),
        .SUBSAMPLE_IDX_OUT   (sub_idx),
        .BAUD_PULSE_OUT      (baud_pulse),
        .MID_PULSE_OUT       (mid_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        ev_t e;
        if (sub_pulse || baud_pulse || mid_pulse) begin
            e.cyc   = cyc;
            e.idx   = sub_idx;
            e.baud  = baud_pulse;
            e.mid   = mid_pulse;
            e.pulse = sub_pulse;
            obs.push_back(e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: first tick D edges after the load edge, then D plus accumulator carry.
    task automatic push_model(input int base, input int d, input int frac, input int limit);
        int  de, t, acc, idx, sum;
        ev_t e;
        de  = (d == 0) ? 1 : d;
        t   = base + de;
        acc = 0;
        idx = 0;
        while (t < limit) begin
            e.cyc   = t;
            e.idx   = idx[2:0];
            e.baud  = (idx == 7);
            e.mid   = MID_ON && (idx == 3);
            e.pulse = 1'b1;
            exp_q.push_back(e);
            sum = acc + frac;
            acc = sum % 16;
            t   = t + de + sum / 16;
            idx = (idx + 1) % 8;
        end
    endtask

    task automatic sync_load(output int base);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        base = cyc;
        obs.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(3);
        n_compared++;
        if (sub_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_pulse got=%b want=0", sub_pulse);
        end
        n_compared++;
        if (sub_idx !== 3'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_idx got=%0d want=0", sub_idx);
        end
        n_compared++;
        if (baud_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_baud got=%b want=0", baud_pulse);
        end
        n_compared++;
        if (mid_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid got=%b want=0", mid_pulse);
        end
        reset = 1'b0;
        obs.delete();
        tick(6);
        n_compared++;
        if (obs.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL disabled_quiet got=%0d events want=0", obs.size());
        end
        obs.delete();
    endtask

    task automatic test_basic;
        int  base;
        ev_t o, e;
        div_int  = 16'd4;
        div_frac = 4'd0;
        enable   = 1'b1;
        tick(1);
        base = cyc;
        obs.delete();
        push_model(base, 4, 0, base + 42);
        tick(42);
        n_compared++;
        if (obs.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL basic_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL basic_event got cyc=%0d idx=%0d b=%b m=%b p=%b want cyc=%0d idx=%0d b=%b m=%b p=%b",
                         o.cyc - base, o.idx, o.baud, o.mid, o.pulse, e.cyc - base, e.idx, e.baud, e.mid, e.pulse);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_frac;
        int  base;
        ev_t o, e;
        div_int  = 16'd3;
        div_frac = 4'd8;
        sync_load(base);
        push_model(base, 3, 8, base + 70);
        tick(70);
        n_compared++;
        if (obs.size() <= 16) begin
            n_mismatched++;
            $display("[TB] FAIL frac_span got=%0d events want>16", obs.size());
        end else if (obs[16].cyc - obs[0].cyc != 56) begin
            n_mismatched++;
            $display("[TB] FAIL frac_span got=%0d want=56", obs[16].cyc - obs[0].cyc);
        end
        n_compared++;
        if (obs.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL frac_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL frac_event got cyc=%0d idx=%0d b=%b p=%b want cyc=%0d idx=%0d b=%b p=%b",
                         o.cyc - base, o.idx, o.baud, o.pulse, e.cyc - base, e.idx, e.baud, e.pulse);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_sync;
        int  b1, b2, b3;
        ev_t o, e;
        div_int  = 16'd4;
        div_frac = 4'd0;
        sync_load(b1);
        push_model(b1, 4, 0, b1 + 26);
        tick(25);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        b2 = cyc;
        push_model(b2, 4, 0, b2 + 8);
        tick(7);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        b3 = cyc;
        push_model(b3, 4, 0, b3 + 14);
        tick(14);
        n_compared++;
        if (obs.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL sync_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL sync_event got cyc=%0d idx=%0d b=%b p=%b want cyc=%0d idx=%0d b=%b p=%b",
                         o.cyc - b1, o.idx, o.baud, o.pulse, e.cyc - b1, e.idx, e.baud, e.pulse);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_enable;
        int  base;
        ev_t o, e;
        div_int  = 16'd6;
        div_frac = 4'd0;
        sync_load(base);
        for (int k = 0; k < 3; k++) begin
            e.cyc   = base + ((k == 0) ? 6 : (k == 1) ? 22 : 28);
            e.idx   = 3'(k);
            e.baud  = 1'b0;
            e.mid   = 1'b0;
            e.pulse = 1'b1;
            exp_q.push_back(e);
        end
        tick(8);
        enable = 1'b0;
        tick(10);
        enable = 1'b1;
        tick(13);
        n_compared++;
        if (obs.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL enable_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL enable_event got cyc=%0d idx=%0d p=%b want cyc=%0d idx=%0d p=%b",
                         o.cyc - base, o.idx, o.pulse, e.cyc - base, e.idx, e.pulse);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_small_div;
        int  base;
        ev_t o, e;
        div_frac = 4'd0;
        for (int d = 0; d < 2; d++) begin
            div_int = 16'(d);
            sync_load(base);
            push_model(base, d, 0, base + 12);
            tick(12);
            n_compared++;
            if (obs.size() != exp_q.size()) begin
                n_mismatched++;
                $display("[TB] FAIL div%0d_count got=%0d want=%0d", d, obs.size(), exp_q.size());
            end
            while (obs.size() > 0 && exp_q.size() > 0) begin
                o = obs.pop_front();
                e = exp_q.pop_front();
                n_compared++;
                if (o !== e) begin
                    n_mismatched++;
                    $display("[TB] FAIL div%0d_event got cyc=%0d idx=%0d b=%b p=%b want cyc=%0d idx=%0d b=%b p=%b",
                             d, o.cyc - base, o.idx, o.baud, o.pulse, e.cyc - base, e.idx, e.baud, e.pulse);
                end
            end
            obs.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_div_change;
        int  base;
        int  times[5];
        ev_t o, e;
        times = '{5, 10, 12, 14, 16};
        div_int  = 16'd5;
        div_frac = 4'd0;
        sync_load(base);
        for (int k = 0; k < 5; k++) begin
            e.cyc   = base + times[k];
            e.idx   = 3'(k);
            e.baud  = 1'b0;
            e.mid   = MID_ON && (k == 3);
            e.pulse = 1'b1;
            exp_q.push_back(e);
        end
        tick(7);
        div_int = 16'd2;
        tick(10);
        n_compared++;
        if (obs.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL divchg_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL divchg_event got cyc=%0d idx=%0d m=%b p=%b want cyc=%0d idx=%0d m=%b p=%b",
                         o.cyc - base, o.idx, o.mid, o.pulse, e.cyc - base, e.idx, e.mid, e.pulse);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        int  base;
        ev_t o, e;
        div_int  = 16'd4;
        div_frac = 4'd0;
        sync_load(base);
        tick(10);
        reset = 1'b1;
        #1;
        n_compared++;
        if (sub_idx !== 3'd0 || sub_pulse !== 1'b0 || baud_pulse !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_clear got idx=%0d p=%b b=%b want idx=0 p=0 b=0",
                     sub_idx, sub_pulse, baud_pulse);
        end
        tick(2);
        reset = 1'b0;
        tick(1);
        base = cyc;
        obs.delete();
        push_model(base, 4, 0, base + 14);
        tick(14);
        n_compared++;
        if (obs.size() != exp_q.size()) begin
            n_mismatched++;
            $display("[TB] FAIL rstmid_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        while (obs.size() > 0 && exp_q.size() > 0) begin
            o = obs.pop_front();
            e = exp_q.pop_front();
            n_compared++;
            if (o !== e) begin
                n_mismatched++;
                $display("[TB] FAIL rstmid_event got cyc=%0d idx=%0d p=%b want cyc=%0d idx=%0d p=%b",
                         o.cyc - base, o.idx, o.pulse, e.cyc - base, e.idx, e.pulse);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_basic;
        test_frac;
        test_sync;
        test_enable;
        test_small_div;
        test_div_change;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
